// File: rtl/tetris_piece_queue.sv
// Next-piece generator: bag-randomised piece types from a Galois LFSR, buffered
// in a small FIFO whose head is presented as a ready-to-spawn active piece.
module tetris_piece_queue #(
  parameter int          NUM_TYPES     = 7,
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [3:0]  SPAWN_X       = 4'd7,
  parameter logic [4:0]  SPAWN_Y       = 5'd0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         seed_load,
  input  logic [15:0]                  seed,
  input  logic                         pop,
  output logic                         piece_valid,
  output logic [13:0]                  spawn_piece,
  output logic [3*PREVIEW_DEPTH-1:0]   preview,
  output logic [PREVIEW_DEPTH-1:0]     preview_valid,
  output logic [3:0]                   bag_remaining
);

  localparam int              FIFO_DEPTH = PREVIEW_DEPTH + 1;
  localparam int              CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0]      ROT_0      = 2'd0;
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;
  localparam logic [CW-1:0]   FIFO_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [7:0] full_mask_f();
    logic [7:0] m;
    m = 8'd0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < NUM_TYPES);
    end
    return m;
  endfunction

  localparam logic [7:0] FULL_MASK = full_mask_f();

  function automatic logic [3:0] popcount_f(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // First set bag bit at or after start, wrapping within the dealt types.
  function automatic logic [2:0] pick_f(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] p;
    logic       found;
    int         idx;
    p     = 3'd0;
    found = 1'b0;
    for (int k = 0; k < NUM_TYPES; k++) begin
      idx = (int'(start) + k) % NUM_TYPES;
      if (!found && mask[idx[2:0]]) begin
        p     = idx[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return p;
  endfunction

  function automatic logic [15:0] lfsr_next_f(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  logic [15:0]   lfsr_r;
  logic [7:0]    mask_r;
  logic [3:0]    bag_remaining_r;
  logic [CW-1:0] count_r;
  logic [2:0]    fifo_r      [FIFO_DEPTH];

  logic          pop_ok_s;
  logic          draw_s;
  logic [2:0]    start_s;
  logic [2:0]    pick_s;
  logic [7:0]    mask_clr_s;
  logic [7:0]    mask_next_s;
  logic [15:0]   lfsr_next_s;
  logic [CW-1:0] tail_s;
  logic [CW-1:0] count_next_s;
  logic [2:0]    fifo_next_s [FIFO_DEPTH];

  // Draw selection, bag update and FIFO shift/push for the coming edge.
  always_comb begin
    pop_ok_s    = pop && (count_r != {CW{1'b0}});
    draw_s      = !seed_load && ((count_r < FIFO_FULL) || pop_ok_s);
    start_s     = ({1'b0, lfsr_r[2:0]} < 4'(NUM_TYPES)) ? lfsr_r[2:0] : 3'd0;
    pick_s      = pick_f(mask_r, start_s);
    mask_clr_s  = mask_r & ~(8'd1 << pick_s);
    tail_s      = pop_ok_s ? (count_r - CNT_ONE) : count_r;
    mask_next_s = mask_r;
    lfsr_next_s = lfsr_next_f(lfsr_r);
    count_next_s = count_r;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_next_s[i] = fifo_r[i];
    end

    if (seed_load) begin
      lfsr_next_s  = (seed == 16'd0) ? LFSR_SEED : seed;
      mask_next_s  = FULL_MASK;
      count_next_s = {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_next_s[i] = 3'd0;
      end
    end else begin
      if (pop_ok_s) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_next_s[i] = fifo_r[i+1];
        end
        fifo_next_s[FIFO_DEPTH-1] = 3'd0;
      end else begin
        count_next_s = count_r;
      end
      if (draw_s) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (CW'(i) == tail_s) begin
            fifo_next_s[i] = pick_s;
          end else begin
            fifo_next_s[i] = fifo_next_s[i];
          end
        end
        mask_next_s = (mask_clr_s == 8'd0) ? FULL_MASK : mask_clr_s;
      end else begin
        mask_next_s = mask_r;
      end
      if (draw_s && !pop_ok_s) begin
        count_next_s = count_r + CNT_ONE;
      end else if (pop_ok_s && !draw_s) begin
        count_next_s = count_r - CNT_ONE;
      end else begin
        count_next_s = count_r;
      end
    end
  end

  // State registers; reset discards every queued piece immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r          <= LFSR_SEED;
      mask_r          <= FULL_MASK;
      bag_remaining_r <= 4'(NUM_TYPES);
      count_r         <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= 3'd0;
      end
    end else begin
      lfsr_r          <= lfsr_next_s;
      mask_r          <= mask_next_s;
      bag_remaining_r <= popcount_f(mask_next_s);
      count_r         <= count_next_s;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_r[i] <= fifo_next_s[i];
      end
    end
  end

  // Outputs decode straight from FIFO registers; unused slots always hold zero.
  always_comb begin
    piece_valid   = (count_r != {CW{1'b0}});
    spawn_piece   = {fifo_r[0], ROT_0, SPAWN_X, SPAWN_Y};
    bag_remaining = bag_remaining_r;
    preview       = {(3*PREVIEW_DEPTH){1'b0}};
    preview_valid = {PREVIEW_DEPTH{1'b0}};
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      preview[3*i +: 3] = fifo_r[i+1];
      preview_valid[i]  = (count_r > CW'(i + 1));
    end
  end

endmodule
